// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared definitions for the AES round controller.
//   AES_BLOCK_W : width of one AES block / round key (128)
//   AES128_NR   : number of rounds for AES-128 (10)
//   RK_IDX_W    : width of the round-key index bus
//   aes_state_e : controller FSM states (IDLE, ROUND, DONE)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES128_NR   = 10;
  localparam int RK_IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

endpackage

// File: rtl/add_roundkey.sv
// ---------------------------------------------------------------------------
// add_roundkey -- AES AddRoundKey step: bytewise XOR of state and round key.
// Purely combinational.
//   state_in  [0:127] : state before key addition
//   round_key [0:127] : round key
//   state_out [0:127] : state_in XOR round_key
// ---------------------------------------------------------------------------
module add_roundkey
  import aes_pkg::*;
(
  input  logic [0:AES_BLOCK_W-1] state_in,
  input  logic [0:AES_BLOCK_W-1] round_key,
  output logic [0:AES_BLOCK_W-1] state_out
);

  for (genvar gi = 0; gi < AES_BLOCK_W / 8; gi++) begin : g_byte
    assign state_out[8*gi +: 8] = state_in[8*gi +: 8] ^ round_key[8*gi +: 8];
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl -- iterative AES encryption round controller.
// Accepts one plaintext block, performs the initial key addition, then drives
// an external combinational round datapath NR times, fetching each round key
// from an external combinational key schedule. One block in flight at a time.
//
// Parameter
//   NR        : number of rounds (1..15), default AES128_NR
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : plaintext handshake, in_data [0:127]
//   out_valid/out_ready   : ciphertext handshake, out_data [0:127]
//   rk_idx [3:0]          : round-key index to the key schedule
//   rk_data [0:127]       : round key for rk_idx (combinational return)
//   dp_state [0:127]      : state to the round datapath
//   dp_final              : 1 = last round, datapath skips MixColumns
//   dp_result [0:127]     : datapath result (combinational return)
//   busy                  : high whenever the FSM is not IDLE
//   abort                 : (only with AES_CTRL_ABORT_EN defined) drops the
//                           block in flight from ROUND or DONE
// Build option: define AES_CTRL_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_BLOCK_W-1] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_BLOCK_W-1] out_data,
  output logic [RK_IDX_W-1:0]    rk_idx,
  input  logic [0:AES_BLOCK_W-1] rk_data,
  output logic [0:AES_BLOCK_W-1] dp_state,
  output logic                   dp_final,
  input  logic [0:AES_BLOCK_W-1] dp_result,
  output logic                   busy
);

  localparam logic [RK_IDX_W-1:0] NR_CNT = RK_IDX_W'(NR);

  aes_state_e             state_q, state_d;
  logic [RK_IDX_W-1:0]    round_cnt_q, round_cnt_d;
  logic [0:AES_BLOCK_W-1] blk_q, blk_d;
  logic [0:AES_BLOCK_W-1] ark_in;
  logic [0:AES_BLOCK_W-1] ark_out;

  // The single key-addition unit serves both the initial whitening (fed from
  // in_data while IDLE) and every round (fed from the datapath). Selecting on
  // state alone guarantees in_data is never sampled outside IDLE.
  assign ark_in = (state_q == ST_IDLE) ? in_data : dp_result;

  add_roundkey u_add_roundkey (
    .state_in  (ark_in),
    .round_key (rk_data),
    .state_out (ark_out)
  );

  assign out_data = blk_q;
  assign dp_state = blk_q;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    blk_d       = blk_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rk_idx      = '0;
    dp_final    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d       = ark_out;
          round_cnt_d = RK_IDX_W'(1);
          state_d     = ST_ROUND;
        end
      end

      ST_ROUND: begin
        rk_idx = round_cnt_q;
        blk_d  = ark_out;
        if (round_cnt_q == NR_CNT) begin
          dp_final = 1'b1;
          state_d  = ST_DONE;
        end else begin
          round_cnt_d = round_cnt_q + RK_IDX_W'(1);
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE does not look at in_valid: the next accept can
        // only happen on the following edge.
        if (out_ready) begin
          state_d     = ST_IDLE;
          round_cnt_d = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        round_cnt_d = '0;
        blk_d       = '0;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    // Abort overrides everything else (including out_ready) outside IDLE.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      round_cnt_d = '0;
      blk_d       = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_cnt_q <= '0;
      blk_q       <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      blk_q       <= blk_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl -- self-checking bench for aes_round_ctrl.
// Provides a reference AES-128 key schedule and round datapath around the
// controller and compares ciphertexts against a whole-block encrypt model.
// Define AES_CTRL_ABORT_EN to also exercise the abort input.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES128_NR;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] dp_state;
  logic         dp_final;
  logic [127:0] dp_result;
  logic         busy;
`ifdef AES_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rks [16];

  aes_round_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .dp_state  (dp_state),
    .dp_final  (dp_final),
    .dp_result (dp_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && out_valid && out_ready) n_done <= n_done + 1;
  end

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // One AES round without key addition; byte i of the block is bits
  // [127-8i -: 8], state[r][c] is byte r+4c.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, r == NR) ^ rks[r];
    return s;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rks[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // External key schedule and datapath, both combinational.
  always_comb rk_data = rks[rk_idx];
  always_comb dp_result = aes_round(dp_state, dp_final);

  // ---------------- bench helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encrypt one block: checks IDLE handshake, rk_idx/dp_final sequence,
  // latency, ciphertext, DONE hold behaviour and the return to IDLE.
  task automatic do_block(input logic [127:0] pt, input int hold,
                          output int acc_cyc, output logic [127:0] ct_obs);
    logic [127:0] exp_ct;
    logic [127:0] held;
    int lat;
    int done0;
    exp_ct = encrypt(pt);
    check("idle_in_ready", in_ready, 1);
    check("idle_rk_idx", rk_idx, 0);
    check("idle_busy", busy, 0);
    done0 = n_done;
    in_data  = pt;
    in_valid = 1'b1;
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("round_rk_idx", rk_idx, lat + 1);
      check("round_dp_final", dp_final, (lat + 1 == NR));
      check("round_in_ready", in_ready, 0);
      check("round_busy", busy, 1);
      // Noise on the input side that must be ignored while busy.
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, NR);
    check("ciphertext", out_data, exp_ct);
    ct_obs = out_data;
    $display("block pt=%h ct=%h latency=%0d accept_cyc=%0d", pt, out_data, lat, acc_cyc);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      check("done_out_valid", out_valid, 1);
      check("done_out_data_stable", out_data, held);
      check("done_in_ready", in_ready, 0);
      check("done_dp_final", dp_final, 0);
      tick();
    end
    // Release with a competing in_valid: it must not be accepted on this edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    check("post_done_busy", busy, 0);
    check("post_done_out_valid", out_valid, 0);
    check("post_done_in_ready", in_ready, 1);
    check("one_completion", n_done - done0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    int acc, prev_acc;
    logic [7:0] inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    set_key(128'h000102030405060708090a0b0c0d0e0f);

    // Reset values
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dp_final", dp_final, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_out_data", out_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer vector with a 5-cycle DONE hold
    do_block(128'h00112233445566778899aabbccddeeff, 5, acc, ct);
    check("kat_ciphertext", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    out_ready = 1'b0;
    tick();

    // Reset in the middle of round 5
    pt = {$urandom, $urandom, $urandom, $urandom};
    in_data  = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("midrst_rk_idx_before", rk_idx, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_dp_final", dp_final, 0);
    check("midrst_rk_idx", rk_idx, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check("midrst_no_out_valid", out_valid, 0);
      tick();
    end
    check("midrst_no_completion", n_done, 1);
    do_block({$urandom, $urandom, $urandom, $urandom}, 1, acc, ct);
    out_ready = 1'b0;
    tick();

    // Random keys, plaintexts and DONE hold times
    for (int k = 0; k < 6; k++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      do_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), acc, ct);
      out_ready = 1'(k % 2);
      repeat ($urandom_range(0, 2)) tick();
      out_ready = 1'b0;
    end

    // Back-to-back with out_ready tied high: accepts 12 cycles apart
    out_ready = 1'b1;
    set_key({$urandom, $urandom, $urandom, $urandom});
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      do_block({$urandom, $urandom, $urandom, $urandom}, 0, acc, ct);
      if (k > 0) check("b2b_accept_spacing", acc - prev_acc, NR + 2);
      prev_acc = acc;
    end
    out_ready = 1'b0;
    tick();

`ifdef AES_CTRL_ABORT_EN
    // Abort during round 3
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_rk_idx_before", rk_idx, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    for (int k = 0; k < 12; k++) begin
      check("abort_no_out_valid", out_valid, 0);
      tick();
    end
    do_block({$urandom, $urandom, $urandom, $urandom}, 2, acc, ct);
    out_ready = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
